cpu_decode_exec: RTL and testbench

- Sequencing core of the 8-bit CPU. Contains the instruction register, the fetch/decode/execute control FSM, the 4-function 8-bit ALU and the ALU flag register.
- Sits between ROM/PC (instruction in, pc_inc/pc_load out) and the register file (A/R0 values in, load strobes out).
- Register storage (A, R0, R1, OUT) and the PC remain outside this block.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_alu8.sv | 39 +++
 rtl/cpu_decode_exec.sv | 120 ++++++++++++
 tb/tb_cpu_decode_exec.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencing core: opcodes, ALU encodings, FSM states.
package cpu_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ALU_OP_W = 2;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDR0 = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDR1 = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h4;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'h8;
    localparam logic [OPC_W-1:0] OP_JC   = 4'h9;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'hA;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } state_e;

    // Maps an opcode to its ALU function; non-ALU opcodes select ADD.
    function automatic logic [ALU_OP_W-1:0] alu_op_of(input logic [OPC_W-1:0] opc);
        logic [ALU_OP_W-1:0] op;
        op = ALU_ADD;
        case (opc)
            OP_SUB:  op = ALU_SUB;
            OP_AND:  op = ALU_AND;
            OP_OR:   op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_alu8.sv
// 4-function 8-bit combinational ALU with zero and carry/borrow outputs.
module cpu_alu8
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [ALU_OP_W-1:0] op,
    output logic [DATA_W-1:0]   result,
    output logic                zero_c,
    output logic                carry_c
);

    logic [DATA_W:0] wide_c;

    // SUB borrow falls out of the 9th bit of the widened difference (set iff a < b).
    always_comb begin
        wide_c  = '0;
        result  = '0;
        carry_c = 1'b0;
        case (op)
            ALU_ADD: begin
                wide_c  = {1'b0, a} + {1'b0, b};
                result  = wide_c[DATA_W-1:0];
                carry_c = wide_c[DATA_W];
            end
            ALU_SUB: begin
                wide_c  = {1'b0, a} - {1'b0, b};
                result  = wide_c[DATA_W-1:0];
                carry_c = wide_c[DATA_W];
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

    assign zero_c = (result == '0);

endmodule

// File: rtl/cpu_decode_exec.sv
// CPU sequencing core: instruction register, fetch/decode/execute FSM, ALU and flag register.
module cpu_decode_exec
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   instr,
    input  logic [DATA_W-1:0]   reg_a,
    input  logic [DATA_W-1:0]   reg_r0,
    output logic [OPC_W-1:0]    opcode,
    output logic [OPC_W-1:0]    operand,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                ir_load,
    output logic                rega_load,
    output logic                r0_load,
    output logic                r1_load,
    output logic                out_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   alu_result,
    output logic                zero,
    output logic                carry,
    output logic                halt
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;

    logic pc_inc_c, pc_load_c, ir_load_c, rega_load_c;
    logic r0_load_c, r1_load_c, out_load_c, halt_c;
    logic alu_zero_c, alu_carry_c;

    assign opcode  = ir_q[DATA_W-1:OPC_W];
    assign operand = ir_q[OPC_W-1:0];
    assign alu_op  = alu_op_of(opcode);

    cpu_alu8 u_alu (
        .a       (reg_a),
        .b       (reg_r0),
        .op      (alu_op),
        .result  (alu_result),
        .zero_c  (alu_zero_c),
        .carry_c (alu_carry_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    // Next state, IR/flag updates and strobe decode.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        ir_load_c   = 1'b0;
        rega_load_c = 1'b0;
        r0_load_c   = 1'b0;
        r1_load_c   = 1'b0;
        out_load_c  = 1'b0;
        halt_c      = 1'b0;
        case (state_q)
            FETCH: begin
                ir_load_c = 1'b1;
                pc_inc_c  = 1'b1;
                ir_d      = instr;
                state_d   = DECODE;
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                state_d = FETCH;
                case (opcode)
                    OP_LDR0: r0_load_c = 1'b1;
                    OP_LDR1: r1_load_c = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        rega_load_c = 1'b1;
                        zero_d      = alu_zero_c;
                        carry_d     = alu_carry_c;
                    end
                    OP_JMP:  pc_load_c  = 1'b1;
                    OP_JZ:   pc_load_c  = zero_q;
                    OP_JC:   pc_load_c  = carry_q;
                    OP_OUT:  out_load_c = 1'b1;
                    OP_HLT:  state_d    = HALTED;
                    default: ;
                endcase
            end
            HALTED:  halt_c  = 1'b1;
            default: state_d = FETCH;
        endcase
    end

    // Reset holds the FSM in FETCH, so the strobes are gated to stay quiet while it is asserted.
    assign pc_inc    = pc_inc_c    & ~reset;
    assign pc_load   = pc_load_c   & ~reset;
    assign ir_load   = ir_load_c   & ~reset;
    assign rega_load = rega_load_c & ~reset;
    assign r0_load   = r0_load_c   & ~reset;
    assign r1_load   = r1_load_c   & ~reset;
    assign out_load  = out_load_c  & ~reset;
    assign halt      = halt_c      & ~reset;

    assign zero  = zero_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_cpu_decode_exec.sv
// Directed bench for cpu_decode_exec: walks the instruction set, flags, halt and mid-instruction reset.
module tb_cpu_decode_exec;

    logic       clk;
    logic       reset;
    logic [7:0] instr;
    logic [7:0] reg_a;
    logic [7:0] reg_r0;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       pc_inc, pc_load, ir_load, rega_load, r0_load, r1_load, out_load;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       zero, carry, halt;

    int checks = 0;
    int errors = 0;

    // {pc_inc, pc_load, ir_load, rega_load, r0_load, r1_load, out_load}
    logic [6:0] strb;
    assign strb = {pc_inc, pc_load, ir_load, rega_load, r0_load, r1_load, out_load};

    localparam logic [6:0] S_NONE  = 7'b0000000;
    localparam logic [6:0] S_FETCH = 7'b1010000;
    localparam logic [6:0] S_PCLD  = 7'b0100000;
    localparam logic [6:0] S_RALD  = 7'b0001000;
    localparam logic [6:0] S_R0LD  = 7'b0000100;
    localparam logic [6:0] S_R1LD  = 7'b0000010;
    localparam logic [6:0] S_OUT   = 7'b0000001;

    cpu_decode_exec dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .reg_a      (reg_a),
        .reg_r0     (reg_r0),
        .opcode     (opcode),
        .operand    (operand),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .ir_load    (ir_load),
        .rega_load  (rega_load),
        .r0_load    (r0_load),
        .r1_load    (r1_load),
        .out_load   (out_load),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .zero       (zero),
        .carry      (carry),
        .halt       (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a FETCH cycle: present ins, check FETCH and DECODE, leave the bench in EXECUTE.
    task automatic fetch_decode(input logic [7:0] ins);
        instr = ins;
        #1;
        chk("fetch_strobes", 32'(strb), 32'(S_FETCH));
        step();
        chk("decode_strobes", 32'(strb), 32'(S_NONE));
        chk("decode_opcode", 32'(opcode), 32'(ins[7:4]));
        step();
    endtask

    initial begin
        reset  = 1'b1;
        instr  = 8'h00;
        reg_a  = 8'h00;
        reg_r0 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'(strb), 32'(S_NONE));
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_flags", 32'({zero, carry}), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // LDR0 #5
        fetch_decode(8'h15);
        chk("ldr0_strobes", 32'(strb), 32'(S_R0LD));
        chk("ldr0_operand", 32'(operand), 32'd5);
        chk("ldr0_opcode", 32'(opcode), 32'd1);
        step();

        // ADD F0+20 = 0x110 -> 0x10, carry
        reg_a = 8'hF0; reg_r0 = 8'h20;
        fetch_decode(8'h30);
        chk("add_result", 32'(alu_result), 32'h10);
        chk("add_aluop", 32'(alu_op), 32'd0);
        chk("add_strobes", 32'(strb), 32'(S_RALD));
        step();
        chk("add_flags_zc", 32'({zero, carry}), 32'b01);

        // SUB 5-5 = 0 -> zero
        reg_a = 8'h05; reg_r0 = 8'h05;
        fetch_decode(8'h40);
        chk("sub0_aluop", 32'(alu_op), 32'd1);
        chk("sub0_result", 32'(alu_result), 32'h00);
        step();
        chk("sub0_flags_zc", 32'({zero, carry}), 32'b10);

        // JZ taken
        fetch_decode(8'h83);
        chk("jz_taken_strobes", 32'(strb), 32'(S_PCLD));
        chk("jz_operand", 32'(operand), 32'd3);
        step();

        // SUB 3-5 = FE with borrow
        reg_a = 8'h03; reg_r0 = 8'h05;
        fetch_decode(8'h40);
        chk("sub_borrow_result", 32'(alu_result), 32'hFE);
        step();
        chk("sub_borrow_flags_zc", 32'({zero, carry}), 32'b01);

        fetch_decode(8'h91);
        chk("jc_taken_strobes", 32'(strb), 32'(S_PCLD));
        step();
        fetch_decode(8'h82);
        chk("jz_not_taken_strobes", 32'(strb), 32'(S_NONE));
        step();

        // AND / OR
        reg_a = 8'hAA; reg_r0 = 8'h0F;
        fetch_decode(8'h50);
        chk("and_result", 32'(alu_result), 32'h0A);
        chk("and_aluop", 32'(alu_op), 32'd2);
        step();
        chk("and_flags_zc", 32'({zero, carry}), 32'b00);
        fetch_decode(8'h60);
        chk("or_result", 32'(alu_result), 32'hAF);
        chk("or_aluop", 32'(alu_op), 32'd3);
        step();
        chk("or_flags_zc", 32'({zero, carry}), 32'b00);

        // JMP and OUT, OUT lasting one cycle
        fetch_decode(8'h7C);
        chk("jmp_strobes", 32'(strb), 32'(S_PCLD));
        step();
        fetch_decode(8'hA0);
        chk("out_strobes", 32'(strb), 32'(S_OUT));
        step();
        chk("out_next_strobes", 32'(strb), 32'(S_FETCH));

        // Unassigned opcode behaves as NOP and leaves flags alone
        fetch_decode(8'hC0);
        chk("nop_c_strobes", 32'(strb), 32'(S_NONE));
        chk("nop_c_aluop", 32'(alu_op), 32'd0);
        step();

        // LDR1 #7
        fetch_decode(8'h27);
        chk("ldr1_strobes", 32'(strb), 32'(S_R1LD));
        step();

        // ADD to set carry before halting
        reg_a = 8'hF0; reg_r0 = 8'h20;
        fetch_decode(8'h30);
        step();
        chk("pre_halt_carry", 32'(carry), 32'd1);

        // HLT: sink state, IR and flags frozen
        fetch_decode(8'hF0);
        chk("hlt_exec_strobes", 32'(strb), 32'(S_NONE));
        chk("hlt_exec_halt", 32'(halt), 32'd0);
        instr = 8'h15; reg_a = 8'h05; reg_r0 = 8'h05;
        step();
        for (int i = 0; i < 12; i++) begin
            chk("halted_halt", 32'(halt), 32'd1);
            chk("halted_strobes", 32'(strb), 32'(S_NONE));
            chk("halted_ir", 32'(opcode), 32'hF);
            chk("halted_flags_zc", 32'({zero, carry}), 32'b01);
            step();
        end

        // Reset mid-HALTED
        #2;
        reset = 1'b1;
        #1;
        chk("rst_halted_halt", 32'(halt), 32'd0);
        chk("rst_halted_opcode", 32'(opcode), 32'd0);
        chk("rst_halted_flags", 32'({zero, carry}), 32'd0);
        chk("rst_halted_strobes", 32'(strb), 32'(S_NONE));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("resume1_strobes", 32'(strb), 32'(S_FETCH));

        // Set carry, then reset in DECODE of a SUB
        reg_a = 8'hF0; reg_r0 = 8'h20;
        fetch_decode(8'h30);
        step();
        chk("pre_rst_carry", 32'(carry), 32'd1);
        instr = 8'h4F;
        step();
        chk("mid_decode_opcode", 32'(opcode), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_decode_opcode", 32'(opcode), 32'd0);
        chk("rst_decode_carry", 32'(carry), 32'd0);
        chk("rst_decode_strobes", 32'(strb), 32'(S_NONE));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("resume2_strobes", 32'(strb), 32'(S_FETCH));
        fetch_decode(8'h15);
        chk("resume2_ldr0", 32'(strb), 32'(S_R0LD));
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
